binary_to_bcd_seq: RTL and testbench

Parametrised, iterative binary-to-BCD converter using shift-and-add-3 (double dabble). It is the multi-cycle successor to the fixed 6-bit converter that feeds the clock and stopwatch seven-segment digit drivers. It generalises input width and digit count, and adds a start/busy/done handshake, an overflow flag and a per-digit leading-zero mask for display blanking. Upstream is the time counters; downstream is the display multiplexer.

---
 rtl/bcd_pkg.sv | 30 +++
 rtl/bcd_digit_adjust.sv | 17 +
 rtl/binary_to_bcd_seq.sv | 123 ++++++++++++
 tb/tb_binary_to_bcd_seq.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared constants, FSM encoding and sizing helper for the iterative
// binary-to-BCD converter.
package bcd_pkg;

  localparam int         BCD_NIBBLE = 4;
  localparam logic [3:0] ADJ_THRESH = 4'd5;
  localparam logic [3:0] ADJ_ADD    = 4'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  // Decimal digits needed to show the largest unsigned value of a given width.
  function automatic int min_digits(input int width);
    longint unsigned v;
    int              d;
    v = (64'd1 << width) - 64'd1;
    d = 1;
    for (int i = 0; i < 20; i++) begin
      if (v >= 64'd10) begin
        v = v / 64'd10;
        d++;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble correction cell: adds 3 to a BCD digit of 5 or more so the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  always_comb begin
    dout = din;
    if (din >= ADJ_THRESH) begin
      dout = din + ADJ_ADD;
    end
  end

endmodule

// File: rtl/binary_to_bcd_seq.sv
// Iterative shift-and-add-3 binary-to-BCD converter with start/busy/done
// handshake, overflow flag and leading-zero mask for display blanking.
module binary_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
)
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [WIDTH-1:0]    bin_in,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic                overflow,
  output logic [DIGITS-1:0]   lz_mask
);

  localparam int ACC_W = BCD_NIBBLE * DIGITS;
  localparam int CW    = $clog2(WIDTH + 1);
  localparam logic [DIGITS-1:0] LZ_RESET = ~(DIGITS'(1));

  state_t            state_reg, state_next;
  logic [ACC_W-1:0]  acc_reg, acc_adj, acc_next;
  logic [WIDTH-1:0]  bin_reg, bin_next;
  logic [CW-1:0]     cnt_reg;
  logic              ovf_reg;

  logic              load, shift_en, finish;

  logic              done_reg;
  logic [ACC_W-1:0]  bcd_reg;
  logic              ovf_out_reg;
  logic [DIGITS-1:0] lz_reg, lz_calc;

  // Per-digit correction and blanking: digit gi is blank when it and every
  // digit above it are zero; the ones digit is never blanked.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      bcd_digit_adjust u_adj (
        .din  (acc_reg[gi*BCD_NIBBLE +: BCD_NIBBLE]),
        .dout (acc_adj[gi*BCD_NIBBLE +: BCD_NIBBLE])
      );
      if (gi == 0) begin : g_ones
        assign lz_calc[gi] = 1'b0;
      end else begin : g_upper
        assign lz_calc[gi] = (acc_reg[ACC_W-1 : gi*BCD_NIBBLE] == '0);
      end
    end
  endgenerate

  // The MSB of the adjusted top digit is a carry of 10^DIGITS lost on shift.
  assign acc_next = {acc_adj[ACC_W-2:0], bin_reg[WIDTH-1]};
  assign bin_next = bin_reg << 1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (cnt_reg == CW'(1)) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    load     = (state_reg == IDLE) && start;
    shift_en = (state_reg == SHIFT);
    finish   = (state_reg == FINISH);
    busy     = (state_reg != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc_reg <= '0;
      bin_reg <= '0;
      cnt_reg <= '0;
      ovf_reg <= 1'b0;
    end else if (load) begin
      acc_reg <= '0;
      bin_reg <= bin_in;
      cnt_reg <= CW'(WIDTH);
      ovf_reg <= 1'b0;
    end else if (shift_en) begin
      acc_reg <= acc_next;
      bin_reg <= bin_next;
      cnt_reg <= cnt_reg - CW'(1);
      ovf_reg <= ovf_reg | acc_adj[ACC_W-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      done_reg    <= 1'b0;
      bcd_reg     <= '0;
      ovf_out_reg <= 1'b0;
      lz_reg      <= LZ_RESET;
    end else begin
      done_reg <= finish;
      if (finish) begin
        bcd_reg     <= acc_reg;
        ovf_out_reg <= ovf_reg;
        lz_reg      <= lz_calc;
      end
    end
  end

  assign done     = done_reg;
  assign bcd_out  = bcd_reg;
  assign overflow = ovf_out_reg;
  assign lz_mask  = lz_reg;

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// Directed bench for binary_to_bcd_seq: an 8-bit/3-digit instance and a
// 6-bit/1-digit instance (overflow case) sharing clock and reset.
module tb_binary_to_bcd_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        a_start, a_busy, a_done, a_ovf;
  logic [7:0]  a_bin;
  logic [11:0] a_bcd;
  logic [2:0]  a_lz;

  logic        b_start, b_busy, b_done, b_ovf;
  logic [5:0]  b_bin;
  logic [3:0]  b_bcd;
  logic [0:0]  b_lz;

  binary_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(a_start), .bin_in(a_bin),
    .busy(a_busy), .done(a_done), .bcd_out(a_bcd), .overflow(a_ovf), .lz_mask(a_lz)
  );

  binary_to_bcd_seq #(.WIDTH(6), .DIGITS(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(b_start), .bin_in(b_bin),
    .busy(b_busy), .done(b_done), .bcd_out(b_bcd), .overflow(b_ovf), .lz_mask(b_lz)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0]  bin;
    logic [11:0] bcd;
    logic [2:0]  lz;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Start one conversion on instance A; lat = edges from acceptance to done.
  task automatic run_a(input logic [7:0] v, output int lat);
    @(negedge clk);
    a_bin   = v;
    a_start = 1'b1;
    @(posedge clk);
    #1 a_start = 1'b0;
    lat = 0;
    while (!a_done && lat < 30) begin
      @(posedge clk);
      #1;
      lat++;
    end
    $display("conv A bin=%0d bcd=%03h ovf=%0b lz=%03b lat=%0d", v, a_bcd, a_ovf, a_lz, lat);
  endtask

  task automatic run_b(input logic [5:0] v, output int lat);
    @(negedge clk);
    b_bin   = v;
    b_start = 1'b1;
    @(posedge clk);
    #1 b_start = 1'b0;
    lat = 0;
    while (!b_done && lat < 30) begin
      @(posedge clk);
      #1;
      lat++;
    end
    $display("conv B bin=%0d bcd=%0h ovf=%0b lz=%0b lat=%0d", v, b_bcd, b_ovf, b_lz, lat);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, ndone, k, e, last_e;
    logic [11:0] got, exp_bcd;
    logic [11:0] b2b_exp [3];

    vecs[0]  = '{8'd0,   12'h000, 3'b110};
    vecs[1]  = '{8'd5,   12'h005, 3'b110};
    vecs[2]  = '{8'd9,   12'h009, 3'b110};
    vecs[3]  = '{8'd10,  12'h010, 3'b100};
    vecs[4]  = '{8'd59,  12'h059, 3'b100};
    vecs[5]  = '{8'd99,  12'h099, 3'b100};
    vecs[6]  = '{8'd100, 12'h100, 3'b000};
    vecs[7]  = '{8'd128, 12'h128, 3'b000};
    vecs[8]  = '{8'd200, 12'h200, 3'b000};
    vecs[9]  = '{8'd255, 12'h255, 3'b000};
    vecs[10] = '{8'd7,   12'h007, 3'b110};
    vecs[11] = '{8'd42,  12'h042, 3'b100};
    b2b_exp[0] = 12'h010;
    b2b_exp[1] = 12'h011;
    b2b_exp[2] = 12'h012;

    reset_n = 1'b0;
    a_start = 1'b0;
    a_bin   = '0;
    b_start = 1'b0;
    b_bin   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_done", 32'(a_done), 32'd0);
    check("rst_bcd", 32'(a_bcd), 32'h000);
    check("rst_ovf", 32'(a_ovf), 32'd0);
    check("rst_lz", 32'(a_lz), 32'b110);
    check("rst_b_lz", 32'(b_lz), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Directed table on the 8-bit instance
    for (int i = 0; i < 12; i++) begin
      run_a(vecs[i].bin, lat);
      check("tbl_lat", 32'(lat), 32'd9);
      check("tbl_bcd", 32'(a_bcd), 32'(vecs[i].bcd));
      check("tbl_ovf", 32'(a_ovf), 32'd0);
      check("tbl_lz", 32'(a_lz), 32'(vecs[i].lz));
      @(posedge clk);
      #1;
      check("tbl_done_pulse", 32'(a_done), 32'd0);
      check("tbl_hold_bcd", 32'(a_bcd), 32'(vecs[i].bcd));
    end

    // Full sweep against a decimal model
    for (int v = 0; v < 256; v++) begin
      exp_bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
      run_a(8'(v), lat);
      check("sweep_lat", 32'(lat), 32'd9);
      check("sweep_bcd", 32'(a_bcd), 32'(exp_bcd));
      check("sweep_ovf", 32'(a_ovf), 32'd0);
    end

    // Single-digit instance: overflow keeps value mod 10
    run_b(6'd63, lat);
    check("b63_lat", 32'(lat), 32'd7);
    check("b63_bcd", 32'(b_bcd), 32'h3);
    check("b63_ovf", 32'(b_ovf), 32'd1);
    run_b(6'd9, lat);
    check("b9_bcd", 32'(b_bcd), 32'h9);
    check("b9_ovf", 32'(b_ovf), 32'd0);
    run_b(6'd10, lat);
    check("b10_bcd", 32'(b_bcd), 32'h0);
    check("b10_ovf", 32'(b_ovf), 32'd1);

    // Start while busy is ignored; bin_in change mid-conversion has no effect
    @(negedge clk);
    a_bin   = 8'd100;
    a_start = 1'b1;
    @(posedge clk);
    #1 a_start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    a_bin   = 8'd7;
    a_start = 1'b1;
    @(posedge clk);
    #1 a_start = 1'b0;
    check("ign_busy", 32'(a_busy), 32'd1);
    ndone = 0;
    got   = '0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (a_done) begin
        ndone++;
        got = a_bcd;
      end
    end
    $display("conv A ignored-start dones=%0d bcd=%03h", ndone, got);
    check("ign_ndone", 32'(ndone), 32'd1);
    check("ign_bcd", 32'(got), 32'h100);

    // Reset mid-conversion aborts without a done pulse
    @(negedge clk);
    a_bin   = 8'd200;
    a_start = 1'b1;
    @(posedge clk);
    #1 a_start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_busy", 32'(a_busy), 32'd0);
    check("abort_bcd", 32'(a_bcd), 32'h000);
    check("abort_done", 32'(a_done), 32'd0);
    check("abort_lz", 32'(a_lz), 32'b110);
    @(negedge clk);
    reset_n = 1'b1;
    ndone = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (a_done) ndone++;
    end
    $display("conv A abort dones=%0d", ndone);
    check("abort_nodone", 32'(ndone), 32'd0);
    run_a(8'd42, lat);
    check("post_abort_bcd", 32'(a_bcd), 32'h042);
    check("post_abort_lat", 32'(lat), 32'd9);

    // start held high: back-to-back conversions every 10 cycles
    @(negedge clk);
    a_bin   = 8'd10;
    a_start = 1'b1;
    k      = 0;
    e      = 0;
    last_e = 0;
    while (k < 3 && e < 60) begin
      @(posedge clk);
      #1;
      e++;
      if (a_done) begin
        $display("conv A b2b bin=%0d bcd=%03h edge=%0d", a_bin, a_bcd, e);
        check("b2b_bcd", 32'(a_bcd), 32'(b2b_exp[k]));
        check("b2b_interval", 32'(e - last_e), 32'd10);
        last_e = e;
        k++;
        a_bin = a_bin + 8'd1;
      end
    end
    a_start = 1'b0;
    check("b2b_count", 32'(k), 32'd3);
    repeat (3) @(posedge clk);
    #1;
    check("b2b_idle", 32'(a_busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
